regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
- Parametrised successor to the attopu 4x16 register file.
- Generic WIDTH x NREGS storage with NREAD combinational read ports, optional write-to-read bypass and optional hardwired-zero register 0.
- Adds a per-register pending (scoreboard) bit so a multi-cycle execute unit can mark a destination busy at issue and release it at writeback; decode uses rd_valid to stall.
- Sits between decode (reads, issue) and writeback (write port) in the attopu core.

Parameters:
- WIDTH, 16, data width of each register.
- NREGS, 4, number of registers, >= 2.
- NREAD, 2, number of read ports, >= 1.
- BYPASS, 1, 1 = a same-cycle write is forwarded to matching reads; 0 = read returns stored value.
- ZERO_REG, 0, 1 = register 0 always reads 0, ignores writes, is never pending.
- AW, $clog2(NREGS), select width (derived, not overridden).

Ports:
- clk  in  1  core clock, all state updates on rising edge.
- rst  in  1  one clock; reset is asynchronous and active-low.
- wr_en  in  1  writeback strobe.
- wr_sel  in  AW  writeback register number.
- wr_data  in  WIDTH  writeback data.
- issue_en  in  1  mark issue_sel pending.
- issue_sel  in  AW  destination register of the issuing instruction.
- flush  in  1  synchronous clear of all pending bits.
- rd_sel  in  NREAD*AW  packed read selects, port i at [i*AW +: AW].
- rd_data  out  NREAD*WIDTH  packed read data.
- rd_valid  out  NREAD  1 = value on port i is architecturally current.
- busy  out  NREGS  pending vector, bit r = register r pending.
- orphan_wb  out  1  sticky: a writeback hit a register that was not pending.
- regs_flat  out  NREGS*WIDTH  debug dump, register r at [r*WIDTH +: WIDTH].

Behaviour:
- Reset (rst low, async): all registers 0, busy all 0, orphan_wb 0. rd_valid then reads all 1, rd_data 0.
- Write: on a clk edge with wr_en, regs[wr_sel] <= wr_data.
  - Ignored when ZERO_REG=1 and wr_sel=0.
  - Ignored when wr_sel >= NREGS (non-power-of-2 depth).
- Read: combinational, zero latency.
  - rd_data[i] = regs[rd_sel[i]].
  - Override 1, BYPASS=1: wr_en and wr_sel==rd_sel[i] (write not ignored) gives wr_data.
  - Override 2: rd_sel[i] >= NREGS, or (ZERO_REG=1 and rd_sel[i]=0), gives 0; this takes precedence over bypass.
- rd_valid[i]:
  - Equals !busy[rd_sel[i]], or 1 when the bypass condition hits port i this cycle.
  - With BYPASS=0, a same-cycle writeback does not make the read valid; it becomes valid next cycle.
  - Out-of-range and zero-reg reads are always valid.
- Pending bits, per register, evaluated at each clk edge in this priority:
  1. flush -> all bits 0. Same-cycle issue_en is discarded; same-cycle wr_en still writes data.
  2. issue_en to r -> bit r = 1. Set wins over a same-cycle writeback clear to r, because the new producer owns r.
  3. wr_en to r -> bit r = 0.
- Issue to a register already pending: bit stays 1, no error.
- Issue to zero reg or out-of-range number: no effect.
- orphan_wb: set at the edge where wr_en targets an in-range, non-zero-reg register whose bit is 0 and flush is low. Cleared only by reset.
- busy is registered; regs_flat reflects registers only, with no bypass.
- Reset mid-operation: state clears immediately, independent of clk.

Decomposition:
- Shared package attopu_pkg: default WIDTH/NREGS constants and a reg-index typedef sized from NREGS.
- One natural sub-module, regfile_scoreboard_bits: holds the NREGS pending flops with flush/issue/wb priority and orphan_wb.
- Storage, read muxes and bypass stay in the top.

Test Plan:
- Reset then read all ports -> rd_data=0, rd_valid all 1, busy=0000, orphan_wb=0; assert rst low mid-run after writes -> all regs 0 before next edge.
- Write 0x1234 to r2 with rd_sel0=2, BYPASS=1 -> same-cycle rd_data0=0x1234, rd_valid0=1; BYPASS=0 -> 0x0000 that cycle, 0x1234 next.
- Issue r3; next cycle read r3 -> rd_valid=0, busy=1000. Writeback 0xBEEF to r3 -> bypassed 0xBEEF valid; next cycle busy=0000.
- Same-cycle issue r1 and writeback r1 with 0x00AA -> r1=0x00AA, busy[1] stays 1.
- Writeback r2 while not pending -> orphan_wb=1 and stays 1 after further traffic. Issue r1,r2 then flush -> busy=0000.
- ZERO_REG=1: write 0x5555 to r0, issue r0 -> reads 0, valid, busy[0]=0. NREGS=6, wr_sel=7 -> no write; rd_sel=7 -> 0.

Source files
------------

// File: rtl/attopu_pkg.sv
// ---------------------------------------------------------------------------
// attopu_pkg
//   Shared constants and helpers for the attopu register file.
//   - ATTOPU_WIDTH / ATTOPU_NREGS : default datapath width and register count
//   - reg_idx_t                   : register number sized from ATTOPU_NREGS
//   - reg_live()                  : whether a register number names a real,
//                                   writable register (in range and not the
//                                   hardwired zero register)
// ---------------------------------------------------------------------------
package attopu_pkg;

    localparam int ATTOPU_WIDTH = 16;
    localparam int ATTOPU_NREGS = 4;

    typedef logic [$clog2(ATTOPU_NREGS)-1:0] reg_idx_t;

    // Register numbers at or above nregs exist only when the depth is not a
    // power of two. Register 0 is dead when it is hardwired to zero.
    function automatic logic reg_live(input int sel, input int nregs, input logic zero_reg);
        return (sel < nregs) && !(zero_reg && (sel == 0));
    endfunction

endpackage

// File: rtl/regfile_scoreboard_bits.sv
// ---------------------------------------------------------------------------
// regfile_scoreboard_bits
//   One pending flop per register plus the sticky orphan-writeback flag.
//   Priority at each edge: flush clears everything, otherwise an issue sets
//   its bit (winning over a same-cycle writeback to the same register) and
//   a writeback clears its bit.
//
//   Ports
//     clk, rst    : clock, asynchronous active-low reset
//     flush       : clear all pending bits, drop any same-cycle issue
//     issue_en    : mark issue_sel pending
//     issue_sel   : destination register of the issuing instruction
//     wr_en       : writeback strobe
//     wr_sel      : writeback register number
//     busy        : pending vector, bit r = register r
//     orphan_wb   : sticky, a writeback found its register not pending
// ---------------------------------------------------------------------------
module regfile_scoreboard_bits
    import attopu_pkg::*;
#(
    parameter int  NREGS    = ATTOPU_NREGS,
    parameter int  ZERO_REG = 0,
    localparam int AW       = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             issue_en,
    input  logic [AW-1:0]    issue_sel,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_sel,
    output logic [NREGS-1:0] busy,
    output logic             orphan_wb
);

    logic             issue_ok;
    logic             wb_ok;
    logic [NREGS-1:0] issue_dec;
    logic [NREGS-1:0] wb_dec;

    assign issue_ok = issue_en && reg_live(32'(issue_sel), NREGS, ZERO_REG != 0);
    assign wb_ok    = wr_en    && reg_live(32'(wr_sel),    NREGS, ZERO_REG != 0);

    // NOTE: every output of a combinational block gets a default before the
    // loop so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        issue_dec = '0;
        wb_dec    = '0;
        for (int r = 0; r < NREGS; r++) begin
            issue_dec[r] = issue_ok && (issue_sel == AW'(r));
            wb_dec[r]    = wb_ok    && (wr_sel    == AW'(r));
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values; orphan_wb below relies on seeing the old busy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy      <= '0;
            orphan_wb <= 1'b0;
        end else begin
            if (flush) begin
                busy <= '0;
            end else begin
                // Clear first, then OR in the set: the new producer owns r.
                busy <= (busy & ~wb_dec) | issue_dec;
            end
            if (!flush && |(wb_dec & ~busy)) begin
                orphan_wb <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// regfile_scoreboard
//   WIDTH x NREGS register file with NREAD combinational read ports, optional
//   write-to-read bypass, optional hardwired-zero register 0 and a per-register
//   pending bit used by decode to stall on in-flight multi-cycle results.
//
//   Ports
//     clk, rst    : clock, asynchronous active-low reset
//     wr_en       : writeback strobe
//     wr_sel      : writeback register number
//     wr_data     : writeback data
//     issue_en    : mark issue_sel pending
//     issue_sel   : destination of the issuing instruction
//     flush       : synchronous clear of all pending bits
//     rd_sel      : packed read selects, port i at [i*AW +: AW]
//     rd_data     : packed read data, port i at [i*WIDTH +: WIDTH]
//     rd_valid    : port i value is architecturally current
//     busy        : pending vector
//     orphan_wb   : sticky, a writeback hit a non-pending register
//     regs_flat   : stored registers (no bypass), r at [r*WIDTH +: WIDTH]
// ---------------------------------------------------------------------------
module regfile_scoreboard
    import attopu_pkg::*;
#(
    parameter int  WIDTH    = ATTOPU_WIDTH,
    parameter int  NREGS    = ATTOPU_NREGS,
    parameter int  NREAD    = 2,
    parameter int  BYPASS   = 1,
    parameter int  ZERO_REG = 0,
    localparam int AW       = $clog2(NREGS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [AW-1:0]          wr_sel,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   issue_en,
    input  logic [AW-1:0]          issue_sel,
    input  logic                   flush,
    input  logic [NREAD*AW-1:0]    rd_sel,
    output logic [NREAD*WIDTH-1:0] rd_data,
    output logic [NREAD-1:0]       rd_valid,
    output logic [NREGS-1:0]       busy,
    output logic                   orphan_wb,
    output logic [NREGS*WIDTH-1:0] regs_flat
);

    logic [WIDTH-1:0] regs [NREGS];
    logic             wr_ok;

    // A write that actually lands: in range and not the zero register.
    assign wr_ok = wr_en && reg_live(32'(wr_sel), NREGS, ZERO_REG != 0);

    // NOTE: the storage is a small flop array that must read zero right after
    // reset, so it is cleared by rst like any other state rather than left
    // uninitialised as a RAM would be.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NREGS; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                if (wr_ok && (wr_sel == AW'(r))) begin
                    regs[r] <= wr_data;
                end
            end
        end
    end

    regfile_scoreboard_bits #(
        .NREGS    (NREGS),
        .ZERO_REG (ZERO_REG)
    ) u_bits (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .issue_en  (issue_en),
        .issue_sel (issue_sel),
        .wr_en     (wr_en),
        .wr_sel    (wr_sel),
        .busy      (busy),
        .orphan_wb (orphan_wb)
    );

    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        logic [AW-1:0]    sel;
        logic [WIDTH-1:0] stored;
        logic             pend;
        logic             dead;
        logic             hit;

        assign sel  = rd_sel[i*AW +: AW];
        // Dead selects (out of range or hardwired zero) read 0 and are always
        // valid; this outranks the bypass.
        assign dead = !reg_live(32'(sel), NREGS, ZERO_REG != 0);
        assign hit  = (BYPASS != 0) && wr_ok && (wr_sel == sel);

        always_comb begin
            stored = '0;
            pend   = 1'b0;
            for (int r = 0; r < NREGS; r++) begin
                if (sel == AW'(r)) begin
                    stored = regs[r];
                    pend   = busy[r];
                end
            end
        end

        assign rd_data[i*WIDTH +: WIDTH] = dead ? '0 : (hit ? wr_data : stored);
        assign rd_valid[i]               = dead || hit || !pend;
    end

    for (genvar r = 0; r < NREGS; r++) begin : g_flat
        assign regs_flat[r*WIDTH +: WIDTH] = regs[r];
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_regfile_scoreboard
//   Three instances: u0 default (BYPASS=1), u1 BYPASS=0 (both share group A
//   stimulus), u2 NREGS=6 ZERO_REG=1 (group B stimulus). A behavioural model
//   holds register contents and pending flags per instance; a compare process
//   checks every output on every falling edge, and directed literal checks pin
//   the model at the interesting points.
// ---------------------------------------------------------------------------
module tb_regfile_scoreboard;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // group A (u0, u1): NREGS=4, AW=2
    logic        wr_en, issue_en, flush;
    logic [1:0]  wr_sel, issue_sel;
    logic [15:0] wr_data;
    logic [3:0]  rd_sel;
    logic [31:0] rdd0, rdd1;
    logic [1:0]  rdv0, rdv1;
    logic [3:0]  bsy0, bsy1;
    logic        orph0, orph1;
    logic [63:0] flat0, flat1;

    // group B (u2): NREGS=6, AW=3
    logic        z_wr_en, z_issue_en, z_flush;
    logic [2:0]  z_wr_sel, z_issue_sel;
    logic [15:0] z_wr_data;
    logic [5:0]  z_rd_sel;
    logic [31:0] rdd2;
    logic [1:0]  rdv2;
    logic [5:0]  bsy2;
    logic        orph2;
    logic [95:0] flat2;

    regfile_scoreboard u0 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .issue_en(issue_en), .issue_sel(issue_sel), .flush(flush), .rd_sel(rd_sel),
        .rd_data(rdd0), .rd_valid(rdv0), .busy(bsy0), .orphan_wb(orph0), .regs_flat(flat0)
    );

    regfile_scoreboard #(.BYPASS(0)) u1 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .issue_en(issue_en), .issue_sel(issue_sel), .flush(flush), .rd_sel(rd_sel),
        .rd_data(rdd1), .rd_valid(rdv1), .busy(bsy1), .orphan_wb(orph1), .regs_flat(flat1)
    );

    regfile_scoreboard #(.NREGS(6), .ZERO_REG(1)) u2 (
        .clk(clk), .rst(rst), .wr_en(z_wr_en), .wr_sel(z_wr_sel), .wr_data(z_wr_data),
        .issue_en(z_issue_en), .issue_sel(z_issue_sel), .flush(z_flush), .rd_sel(z_rd_sel),
        .rd_data(rdd2), .rd_valid(rdv2), .busy(bsy2), .orphan_wb(orph2), .regs_flat(flat2)
    );

    int n_checks = 0;
    int n_err    = 0;
    bit run      = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_nregs [3] = '{4, 4, 6};
    bit          m_byp   [3] = '{1'b1, 1'b0, 1'b1};
    bit          m_zr    [3] = '{1'b0, 1'b0, 1'b1};
    logic [15:0] m_regs  [3][8];
    bit          m_busy  [3][8];
    bit          m_orph  [3];

    function automatic bit live(input int k, input int sel);
        return (sel < m_nregs[k]) && !(m_zr[k] && sel == 0);
    endfunction

    function automatic void m_clear();
        for (int k = 0; k < 3; k++) begin
            m_orph[k] = 1'b0;
            for (int r = 0; r < 8; r++) begin
                m_regs[k][r] = 16'h0;
                m_busy[k][r] = 1'b0;
            end
        end
    endfunction

    function automatic void m_edge(input int k, input bit wen, input int wsel, input logic [15:0] wdata,
                                   input bit ien, input int isel, input bit fl);
        bit wlands;
        wlands = wen && live(k, wsel);
        if (wlands && !fl && !m_busy[k][wsel]) m_orph[k] = 1'b1;
        if (wlands) m_regs[k][wsel] = wdata;
        if (fl) begin
            for (int r = 0; r < 8; r++) m_busy[k][r] = 1'b0;
        end else begin
            if (wlands) m_busy[k][wsel] = 1'b0;
            if (ien && live(k, isel)) m_busy[k][isel] = 1'b1;
        end
    endfunction

    function automatic void m_read(input int k, input int sel, input bit wen, input int wsel,
                                   input logic [15:0] wdata, output logic [15:0] d, output bit v);
        if (!live(k, sel)) begin
            d = 16'h0; v = 1'b1;
        end else if (m_byp[k] && wen && wsel == sel) begin
            d = wdata; v = 1'b1;
        end else begin
            d = m_regs[k][sel]; v = !m_busy[k][sel];
        end
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_clear();
        end else begin
            m_edge(0, wr_en, int'(wr_sel), wr_data, issue_en, int'(issue_sel), flush);
            m_edge(1, wr_en, int'(wr_sel), wr_data, issue_en, int'(issue_sel), flush);
            m_edge(2, z_wr_en, int'(z_wr_sel), z_wr_data, z_issue_en, int'(z_issue_sel), z_flush);
        end
    end

    task automatic cmp_inst(input int k, input logic [31:0] rdd, input logic [1:0] rdv,
                            input logic [7:0] bsy, input logic orph, input logic [127:0] flat,
                            input bit wen, input int wsel, input logic [15:0] wdata,
                            input int sel0, input int sel1);
        logic [15:0]  d;
        bit           v;
        logic [31:0]  ed;
        logic [1:0]   ev;
        logic [7:0]   eb;
        logic [127:0] ef;
        m_read(k, sel0, wen, wsel, wdata, d, v);
        ed[15:0] = d; ev[0] = v;
        m_read(k, sel1, wen, wsel, wdata, d, v);
        ed[31:16] = d; ev[1] = v;
        eb = '0;
        ef = '0;
        for (int r = 0; r < m_nregs[k]; r++) begin
            eb[r]          = m_busy[k][r];
            ef[r*16 +: 16] = m_regs[k][r];
        end
        check($sformatf("u%0d.rd_data", k),   128'(rdd),  128'(ed));
        check($sformatf("u%0d.rd_valid", k),  128'(rdv),  128'(ev));
        check($sformatf("u%0d.busy", k),      128'(bsy),  128'(eb));
        check($sformatf("u%0d.orphan_wb", k), 128'(orph), 128'(m_orph[k]));
        check($sformatf("u%0d.regs_flat", k), flat,       ef);
    endtask

    always @(negedge clk) begin
        if (run) begin
            cmp_inst(0, rdd0, rdv0, 8'(bsy0), orph0, 128'(flat0), wr_en, int'(wr_sel), wr_data,
                     int'(rd_sel[1:0]), int'(rd_sel[3:2]));
            cmp_inst(1, rdd1, rdv1, 8'(bsy1), orph1, 128'(flat1), wr_en, int'(wr_sel), wr_data,
                     int'(rd_sel[1:0]), int'(rd_sel[3:2]));
            cmp_inst(2, rdd2, rdv2, 8'(bsy2), orph2, 128'(flat2), z_wr_en, int'(z_wr_sel), z_wr_data,
                     int'(z_rd_sel[2:0]), int'(z_rd_sel[5:3]));
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        wr_en = 1'b0; issue_en = 1'b0; flush = 1'b0;
        z_wr_en = 1'b0; z_issue_en = 1'b0; z_flush = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    initial begin
        idle();
        wr_sel = '0; issue_sel = '0; wr_data = '0; rd_sel = '0;
        z_wr_sel = '0; z_issue_sel = '0; z_wr_data = '0; z_rd_sel = '0;
        repeat (2) @(posedge clk);
        #1;
        run = 1'b1;

        // Reset state
        settle();
        check("rst.rd_data",   128'(rdd0),  128'(32'h0));
        check("rst.rd_valid",  128'(rdv0),  128'(2'b11));
        check("rst.busy",      128'(bsy0),  128'(4'b0000));
        check("rst.orphan_wb", 128'(orph0), 128'(1'b0));
        tick();
        rst = 1'b1;

        // Flush with writeback: data lands, no orphan
        flush = 1'b1; wr_en = 1'b1; wr_sel = 2'd0; wr_data = 16'h0101;
        settle(); tick(); idle();
        settle();
        check("flushwr.orphan", 128'(orph0),       128'(1'b0));
        check("flushwr.r0",     128'(flat0[15:0]), 128'(16'h0101));
        tick();

        // Write r2 with read on port 0: bypass vs no bypass
        wr_en = 1'b1; wr_sel = 2'd2; wr_data = 16'h1234; rd_sel = {2'd3, 2'd2};
        settle();
        check("byp.u0.data",  128'(rdd0[15:0]), 128'(16'h1234));
        check("byp.u0.valid", 128'(rdv0[0]),    128'(1'b1));
        check("nobyp.u1.data", 128'(rdd1[15:0]), 128'(16'h0000));
        tick(); idle();
        settle();
        check("nobyp.u1.next", 128'(rdd1[15:0]), 128'(16'h1234));
        check("orphan.set",    128'(orph0),      128'(1'b1));
        tick();

        // Issue r3, then read it pending, then writeback
        issue_en = 1'b1; issue_sel = 2'd3; rd_sel = {2'd0, 2'd3};
        settle(); tick(); idle();
        settle();
        check("issue.valid", 128'(rdv0[0]), 128'(1'b0));
        check("issue.busy",  128'(bsy0),    128'(4'b1000));
        tick();
        wr_en = 1'b1; wr_sel = 2'd3; wr_data = 16'hBEEF;
        settle();
        check("wb.u0.data",  128'(rdd0[15:0]), 128'(16'hBEEF));
        check("wb.u0.valid", 128'(rdv0[0]),    128'(1'b1));
        check("wb.u1.valid", 128'(rdv1[0]),    128'(1'b0));
        tick(); idle();
        settle();
        check("wb.busy",      128'(bsy0),    128'(4'b0000));
        check("wb.u1.valid2", 128'(rdv1[0]), 128'(1'b1));
        tick();

        // Same-cycle issue and writeback to r1: set wins
        issue_en = 1'b1; issue_sel = 2'd1; wr_en = 1'b1; wr_sel = 2'd1; wr_data = 16'h00AA;
        rd_sel = {2'd1, 2'd3};
        settle(); tick(); idle();
        settle();
        check("setwins.r1",    128'(flat0[31:16]), 128'(16'h00AA));
        check("setwins.busy",  128'(bsy0),         128'(4'b0010));
        check("setwins.valid", 128'(rdv0[1]),      128'(1'b0));
        tick();

        // Issue r2, then flush with same-cycle issue r3 and write r0
        issue_en = 1'b1; issue_sel = 2'd2;
        settle(); tick(); idle();
        settle();
        check("pre_flush.busy", 128'(bsy0), 128'(4'b0110));
        flush = 1'b1; issue_en = 1'b1; issue_sel = 2'd3; wr_en = 1'b1; wr_sel = 2'd0; wr_data = 16'h7777;
        tick(); idle();
        settle();
        check("flush.busy",   128'(bsy0),        128'(4'b0000));
        check("flush.r0",     128'(flat0[15:0]), 128'(16'h7777));
        check("orphan.stick", 128'(orph0),       128'(1'b1));
        tick();

        // Asynchronous reset mid-run
        #2;
        rst = 1'b0;
        #1;
        check("arst.u0.regs",   128'(flat0), 128'(64'h0));
        check("arst.u1.regs",   128'(flat1), 128'(64'h0));
        check("arst.busy",      128'(bsy0),  128'(4'b0000));
        check("arst.orphan_wb", 128'(orph0), 128'(1'b0));
        settle();
        rst = 1'b1;
        tick();

        // ZERO_REG: write and issue r0 are ignored
        z_wr_en = 1'b1; z_wr_sel = 3'd0; z_wr_data = 16'h5555;
        z_issue_en = 1'b1; z_issue_sel = 3'd0; z_rd_sel = {3'd0, 3'd0};
        settle();
        check("zr.rd_data",  128'(rdd2), 128'(32'h0));
        check("zr.rd_valid", 128'(rdv2), 128'(2'b11));
        tick(); idle();
        settle();
        check("zr.busy",   128'(bsy2),        128'(6'b000000));
        check("zr.r0",     128'(flat2[15:0]), 128'(16'h0));
        check("zr.orphan", 128'(orph2),       128'(1'b0));
        tick();

        // Out-of-range write/issue/read on the 6-deep instance
        z_wr_en = 1'b1; z_wr_sel = 3'd7; z_wr_data = 16'h7777;
        z_issue_en = 1'b1; z_issue_sel = 3'd6; z_rd_sel = {3'd5, 3'd7};
        settle();
        check("oor.rd_data",  128'(rdd2), 128'(32'h0));
        check("oor.rd_valid", 128'(rdv2), 128'(2'b11));
        tick(); idle();
        settle();
        check("oor.regs",   flat2,         128'(96'h0));
        check("oor.busy",   128'(bsy2),    128'(6'b000000));
        check("oor.orphan", 128'(orph2),   128'(1'b0));
        tick();

        // Top register r5 written with bypass on port 1
        z_wr_en = 1'b1; z_wr_sel = 3'd5; z_wr_data = 16'hABCD;
        settle();
        check("r5.byp", 128'(rdd2[31:16]), 128'(16'hABCD));
        tick(); idle();
        settle();
        check("r5.stored", 128'(flat2[95:80]), 128'(16'hABCD));
        check("r5.orphan", 128'(orph2),        128'(1'b1));
        tick();

        // Issue r4 then read it pending
        z_issue_en = 1'b1; z_issue_sel = 3'd4;
        settle(); tick(); idle();
        z_rd_sel = {3'd5, 3'd4};
        settle();
        check("r4.valid", 128'(rdv2), 128'(2'b10));
        check("r4.busy",  128'(bsy2), 128'(6'b010000));
        tick();

        run = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
